ro_puf_challenge_sequencer: RTL and testbench



---
 rtl/ro_puf_challenge_sequencer_pkg.sv | 32 +++
 rtl/ro_puf_challenge_sequencer_phase_timer.sv | 37 +++
 rtl/ro_puf_challenge_sequencer.sv | 169 ++++++++++++++++
 tb/tb_ro_puf_challenge_sequencer.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_puf_challenge_sequencer_pkg.sv
// Shared definitions for the RO-PUF challenge sequencer: FSM state encoding,
// default phase durations and the PUF core measurement window.
package ro_puf_challenge_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_RUN    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam int unsigned DEF_NBITS         = 16;
    localparam int unsigned DEF_CLEAR_CYCLES  = 4;
    localparam int unsigned DEF_RUN_CYCLES    = 4104;
    localparam int unsigned DEF_SETTLE_CYCLES = 2;

    // Core clock counter terminal value; RUN must exceed this so the RO
    // counters have frozen before the comparison bit is read.
    localparam int unsigned CORE_WINDOW = 32'h0000_0fff;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/ro_puf_challenge_sequencer_phase_timer.sv
// Loadable down-counter with terminal-count flag; times the CLEAR, RUN and
// SETTLE phases. Loading N-1 makes the phase last exactly N cycles.
module ro_puf_challenge_sequencer_phase_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load wins, otherwise decrement and hold at zero
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == '0);

endmodule

// File: rtl/ro_puf_challenge_sequencer.sv
// Sequencer in front of the 16-RO PUF core: for each response bit it clears
// the core, runs one measurement window on a stride-selected RO pair, samples
// the comparison bit and finally offers the packed word with valid/ready.
module ro_puf_challenge_sequencer
    import ro_puf_challenge_sequencer_pkg::*;
#(
    parameter int unsigned NBITS         = DEF_NBITS,
    parameter int unsigned CLEAR_CYCLES  = DEF_CLEAR_CYCLES,
    parameter int unsigned RUN_CYCLES    = DEF_RUN_CYCLES,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       stride,
    output logic [3:0]       ro_select1,
    output logic [3:0]       ro_select2,
    output logic             ro_enable,
    output logic             ro_reset,
    input  logic             puf_bit,
    output logic [NBITS-1:0] response,
    output logic             response_valid,
    input  logic             response_ready,
    output logic             busy,
    output logic             error
);

    localparam int unsigned PW = $clog2(max3(CLEAR_CYCLES, RUN_CYCLES, SETTLE_CYCLES) + 1);
    localparam int unsigned KW = $clog2(NBITS + 1);

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d, k_next;
    logic [3:0]       stride_q, stride_d;
    logic [3:0]       sel1_q, sel1_d;
    logic [3:0]       sel2_q, sel2_d;
    logic [NBITS-1:0] response_q, response_d;
    logic             error_q, error_d;

    logic             timer_load;
    logic [PW-1:0]    timer_val;
    logic             timer_tc;

    logic             accept;
    logic             capture;
    logic             last_bit;

    assign accept   = (state_q == ST_IDLE) && start && (stride != 4'd0);
    assign capture  = (state_q == ST_SETTLE) && timer_tc;
    assign last_bit = (k_q == KW'(NBITS - 1));
    assign k_next   = k_q + KW'(1);

    ro_puf_challenge_sequencer_phase_timer #(
        .W (PW)
    ) u_phase_timer (
        .clk_i      (clock),
        .rst_i      (reset),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .tc_o       (timer_tc)
    );

    // FSM next state and phase timer loads
    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        timer_val  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_CLEAR;
                    timer_load = 1'b1;
                    timer_val  = PW'(CLEAR_CYCLES - 1);
                end
            end
            ST_CLEAR: begin
                if (timer_tc) begin
                    state_d    = ST_RUN;
                    timer_load = 1'b1;
                    timer_val  = PW'(RUN_CYCLES - 1);
                end
            end
            ST_RUN: begin
                if (timer_tc) begin
                    state_d    = ST_SETTLE;
                    timer_load = 1'b1;
                    timer_val  = PW'(SETTLE_CYCLES - 1);
                end
            end
            ST_SETTLE: begin
                if (timer_tc) begin
                    if (last_bit) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_CLEAR;
                        timer_load = 1'b1;
                        timer_val  = PW'(CLEAR_CYCLES - 1);
                    end
                end
            end
            ST_DONE: begin
                if (response_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: stride latch, bit index, selects, response, error
    always_comb begin
        k_d        = k_q;
        stride_d   = stride_q;
        sel1_d     = sel1_q;
        sel2_d     = sel2_q;
        response_d = response_q;
        error_d    = (state_q == ST_IDLE) && start && (stride == 4'd0);
        if (accept) begin
            stride_d   = stride;
            response_d = '0;
            k_d        = '0;
            sel1_d     = 4'd0;
            sel2_d     = stride;
        end
        if (capture) begin
            for (int unsigned i = 0; i < NBITS; i++) begin
                if (k_q == KW'(i)) begin
                    response_d[i] = puf_bit;
                end
            end
            if (!last_bit) begin
                k_d    = k_next;
                // Selects wrap mod 16 even when k runs past 15
                sel1_d = 4'(k_next);
                sel2_d = 4'(k_next) + stride_q;
            end
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            stride_q   <= '0;
            sel1_q     <= 4'd0;
            sel2_q     <= 4'd1;
            response_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            stride_q   <= stride_d;
            sel1_q     <= sel1_d;
            sel2_q     <= sel2_d;
            response_q <= response_d;
            error_q    <= error_d;
        end
    end

    assign ro_select1     = sel1_q;
    assign ro_select2     = sel2_q;
    assign ro_enable      = (state_q == ST_RUN);
    assign ro_reset       = (state_q == ST_IDLE) || (state_q == ST_CLEAR) || (state_q == ST_DONE);
    assign response       = response_q;
    assign response_valid = (state_q == ST_DONE);
    assign busy           = (state_q != ST_IDLE);
    assign error          = error_q;

endmodule

// File: tb/tb_ro_puf_challenge_sequencer.sv
// Self-checking bench for ro_puf_challenge_sequencer. A behavioural PUF core
// stand-in compares fixed per-RO frequencies; its registered output is
// inverted while enable is high so a mistimed capture shows up.
module tb_ro_puf_challenge_sequencer;

    localparam int unsigned LIMIT = 6000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    // Main DUT: NBITS=4, default phase durations
    logic        start = 1'b0;
    logic [3:0]  stride = 4'd0;
    logic [3:0]  ro_select1, ro_select2;
    logic        ro_enable, ro_reset;
    logic        puf_bit;
    logic [3:0]  response;
    logic        response_valid;
    logic        response_ready = 1'b0;
    logic        busy, error;

    // Second DUT: NBITS=17, short phases, for select wrap-around
    logic        s17_start = 1'b0;
    logic [3:0]  s17_stride = 4'd0;
    logic [3:0]  s17_sel1, s17_sel2;
    logic        s17_enable, s17_rst;
    logic        s17_puf;
    logic [16:0] s17_response;
    logic        s17_valid;
    logic        s17_ready = 1'b0;
    logic        s17_busy, s17_error;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];

    always #5 clock = ~clock;

    ro_puf_challenge_sequencer #(
        .NBITS (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .stride         (stride),
        .ro_select1     (ro_select1),
        .ro_select2     (ro_select2),
        .ro_enable      (ro_enable),
        .ro_reset       (ro_reset),
        .puf_bit        (puf_bit),
        .response       (response),
        .response_valid (response_valid),
        .response_ready (response_ready),
        .busy           (busy),
        .error          (error)
    );

    ro_puf_challenge_sequencer #(
        .NBITS         (17),
        .CLEAR_CYCLES  (3),
        .RUN_CYCLES    (8),
        .SETTLE_CYCLES (2)
    ) u17 (
        .clock          (clock),
        .reset          (reset),
        .start          (s17_start),
        .stride         (s17_stride),
        .ro_select1     (s17_sel1),
        .ro_select2     (s17_sel2),
        .ro_enable      (s17_enable),
        .ro_reset       (s17_rst),
        .puf_bit        (s17_puf),
        .response       (s17_response),
        .response_valid (s17_valid),
        .response_ready (s17_ready),
        .busy           (s17_busy),
        .error          (s17_error)
    );

    function automatic int unsigned ro_freq(input logic [3:0] s);
        case (s)
            4'd0:  return 50;
            4'd1:  return 40;
            4'd2:  return 45;
            4'd3:  return 30;
            4'd4:  return 20;
            4'd5:  return 60;
            4'd6:  return 35;
            4'd7:  return 55;
            4'd8:  return 10;
            4'd9:  return 65;
            4'd10: return 25;
            4'd11: return 70;
            4'd12: return 15;
            4'd13: return 48;
            4'd14: return 33;
            default: return 58;
        endcase
    endfunction

    function automatic logic cmp_bit(input logic [3:0] a, input logic [3:0] b);
        return ro_freq(a) > ro_freq(b);
    endfunction

    function automatic logic [63:0] model_resp(input int unsigned nbits, input logic [3:0] strd);
        logic [63:0] r;
        logic [3:0]  s1, s2;
        r = '0;
        for (int unsigned k = 0; k < nbits; k++) begin
            s1   = 4'(k);
            s2   = 4'(k) + strd;
            r[k] = cmp_bit(s1, s2);
        end
        return r;
    endfunction

    // PUF core stand-ins: registered comparison, garbage while measuring
    always @(posedge clock) begin
        puf_bit <= ro_enable  ? ~cmp_bit(ro_select1, ro_select2) : cmp_bit(ro_select1, ro_select2);
        s17_puf <= s17_enable ? ~cmp_bit(s17_sel1, s17_sel2)     : cmp_bit(s17_sel1, s17_sel2);
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({ro_select1, ro_select2} !== 8'h01) begin
            n_fail++;
            $display("FAIL reset_selects: got %h expected 01", {ro_select1, ro_select2});
        end
        n_checks++;
        if ({ro_enable, ro_reset, busy, error, response_valid} !== 5'b01000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 01000", {ro_enable, ro_reset, busy, error, response_valid});
        end
        n_checks++;
        if (response !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_response: got %h expected 0", response);
        end
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({ro_enable, ro_reset, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL idle_ctrl: got %b expected 010", {ro_enable, ro_reset, busy});
        end
    endtask

    task automatic test_stride_zero();
        start  = 1'b1;
        stride = 4'd0;
        @(negedge clock);
        start = 1'b0;
        n_checks++;
        if ({error, busy, ro_reset} !== 3'b101) begin
            n_fail++;
            $display("FAIL stride0_pulse: got err/busy/rst %b expected 101", {error, busy, ro_reset});
        end
        @(negedge clock);
        n_checks++;
        if ({error, busy, ro_reset} !== 3'b001) begin
            n_fail++;
            $display("FAIL stride0_after: got err/busy/rst %b expected 001", {error, busy, ro_reset});
        end
    endtask

    task automatic test_main_sequence();
        int          t, n;
        logic [63:0] exp_r, got;
        exp_r = model_resp(4, 4'd1);
        exp_q.push_back(exp_r);
        start  = 1'b1;
        stride = 4'd1;
        @(negedge clock);
        start  = 1'b0;
        stride = 4'd9;  // must not affect the running sequence
        t = 0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (ro_select1 !== 4'(k) || ro_select2 !== 4'(k + 1)) begin
                n_fail++;
                $display("FAIL pair%0d_selects: got (%0d,%0d) expected (%0d,%0d)",
                         k, ro_select1, ro_select2, k, k + 1);
            end
            n = 0;
            while (ro_reset === 1'b1 && busy === 1'b1 && n < LIMIT) begin
                @(negedge clock); n++; t++;
            end
            n_checks++;
            if (n != 4) begin
                n_fail++;
                $display("FAIL pair%0d_clear_len: got %0d expected 4", k, n);
            end
            n = 0;
            while (ro_enable === 1'b1 && n < LIMIT) begin
                @(negedge clock); n++; t++;
            end
            n_checks++;
            if (n != 4104) begin
                n_fail++;
                $display("FAIL pair%0d_run_len: got %0d expected 4104", k, n);
            end
            n = 0;
            while (ro_enable === 1'b0 && ro_reset === 1'b0 && n < LIMIT) begin
                @(negedge clock); n++; t++;
            end
            n_checks++;
            if (n != 2) begin
                n_fail++;
                $display("FAIL pair%0d_settle_len: got %0d expected 2", k, n);
            end
            n_checks++;
            if (response[k] !== exp_r[k]) begin
                n_fail++;
                $display("FAIL pair%0d_capture: got %b expected %b", k, response[k], exp_r[k]);
            end
        end
        n_checks++;
        if (response_valid !== 1'b1 || t != 16440) begin
            n_fail++;
            $display("FAIL main_latency: got valid=%b after %0d cycles expected valid=1 after 16440", response_valid, t);
        end
        got = {60'd0, response};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL main_response: got %h with empty scoreboard expected entry", got);
        end else begin
            exp_r = exp_q.pop_front();
            if (got !== exp_r || response !== 4'b1101) begin
                n_fail++;
                $display("FAIL main_response: got %h expected %h", got, exp_r);
            end
        end
    endtask

    task automatic test_done_hold();
        logic [3:0] r0;
        int         bad;
        r0  = response;
        bad = 0;
        response_ready = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            n_checks++;
            if (response_valid !== 1'b1 || response !== r0) begin
                n_fail++;
                bad++;
                if (bad < 4)
                    $display("FAIL done_hold: got valid=%b resp=%h expected valid=1 resp=%h", response_valid, response, r0);
            end
        end
        response_ready = 1'b1;
        start  = 1'b1;
        stride = 4'd2;
        @(negedge clock);
        response_ready = 1'b0;
        start = 1'b0;
        n_checks++;
        if ({response_valid, busy} !== 2'b00 || response !== r0) begin
            n_fail++;
            $display("FAIL done_handshake: got valid/busy=%b resp=%h expected 00 resp=%h", {response_valid, busy}, response, r0);
        end
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b0 || response !== r0) begin
            n_fail++;
            $display("FAIL done_start_ignored: got busy=%b resp=%h expected busy=0 resp=%h", busy, response, r0);
        end
    endtask

    task automatic test_reset_mid_run();
        int          t;
        logic [63:0] exp_r, got;
        start  = 1'b1;
        stride = 4'd3;
        @(negedge clock);
        start = 1'b0;
        t = 0;
        while (t < 10223) begin
            @(negedge clock); t++;
        end
        n_checks++;
        if (ro_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_enable: got %b expected 1", ro_enable);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_checks++;
        if ({ro_enable, ro_reset, busy, response_valid} !== 4'b0100 || response !== 4'h0
            || {ro_select1, ro_select2} !== 8'h01) begin
            n_fail++;
            $display("FAIL midrun_reset: got en/rst/busy/valid=%b resp=%h sel=%h expected 0100 0 01",
                     {ro_enable, ro_reset, busy, response_valid}, response, {ro_select1, ro_select2});
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (response_valid !== 1'b0) begin
                n_checks++;
                n_fail++;
                $display("FAIL midrun_no_valid: got %b expected 0", response_valid);
            end
        end
        exp_q.push_back(model_resp(4, 4'd5));
        start  = 1'b1;
        stride = 4'd5;
        @(negedge clock);
        start  = 1'b0;
        stride = 4'd0;
        t = 0;
        while (response_valid !== 1'b1 && t < 20000) begin
            @(negedge clock); t++;
        end
        n_checks++;
        if (t != 16440) begin
            n_fail++;
            $display("FAIL fresh_latency: got %0d expected 16440", t);
        end
        got = {60'd0, response};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL fresh_response: got %h with empty scoreboard expected entry", got);
        end else begin
            exp_r = exp_q.pop_front();
            if (got !== exp_r) begin
                n_fail++;
                $display("FAIL fresh_response: got %h expected %h", got, exp_r);
            end
        end
        response_ready = 1'b1;
        @(negedge clock);
        response_ready = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL fresh_release: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_wrap17();
        int          n;
        logic [63:0] exp_r, got;
        exp_q.push_back(model_resp(17, 4'd15));
        s17_start  = 1'b1;
        s17_stride = 4'd15;
        @(negedge clock);
        s17_start = 1'b0;
        n = 0;
        while (!(s17_busy === 1'b1 && s17_sel1 === 4'd15) && n < 500) begin
            @(negedge clock); n++;
        end
        n_checks++;
        if (s17_sel1 !== 4'd15 || s17_sel2 !== 4'd14) begin
            n_fail++;
            $display("FAIL wrap_k15: got (%0d,%0d) expected (15,14)", s17_sel1, s17_sel2);
        end
        n = 0;
        while (s17_sel1 !== 4'd0 && n < 500) begin
            @(negedge clock); n++;
        end
        n_checks++;
        if (s17_sel1 !== 4'd0 || s17_sel2 !== 4'd15 || s17_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_k16: got (%0d,%0d) busy=%b expected (0,15) busy=1", s17_sel1, s17_sel2, s17_busy);
        end
        n = 0;
        while (s17_valid !== 1'b1 && n < 500) begin
            @(negedge clock); n++;
        end
        got = {47'd0, s17_response};
        n_checks++;
        if (s17_valid !== 1'b1 || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL wrap_response: got valid=%b resp=%h expected valid response", s17_valid, got);
        end else begin
            exp_r = exp_q.pop_front();
            if (got !== exp_r) begin
                n_fail++;
                $display("FAIL wrap_response: got %h expected %h", got, exp_r);
            end
        end
        s17_ready = 1'b1;
        @(negedge clock);
        s17_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stride_zero();
        test_main_sequence();
        test_done_hold();
        test_reset_mid_run();
        test_wrap17();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
